// File: rtl/regfile_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_param : 2^ADDR_W x DATA_W register file, two registered read ports,
//                 command-bus loading, write-first bypass, CLEAR sequencer.
// Revision 1.0
// ----------------------------------------------------------------------------
module regfile_param #(
   parameter int DATA_W    = 4,
   parameter int ADDR_W    = 4,
   parameter bit ZERO_REG0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [DATA_W-1:0] out_r1,
   output logic [DATA_W-1:0] out_r2,
   output logic              busy,
   output logic              wr_done,
   output logic              clr_done
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   localparam logic [2:0] OP_SET_RR1   = 3'd1;
   localparam logic [2:0] OP_SET_RR2   = 3'd2;
   localparam logic [2:0] OP_SET_WR    = 3'd3;
   localparam logic [2:0] OP_SET_WDATA = 3'd4;
   localparam logic [2:0] OP_WRITE     = 3'd5;
   localparam logic [2:0] OP_CLEAR     = 3'd6;

   typedef enum logic {
      IDLE = 1'b0,
      CLR  = 1'b1
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] rr1, rr2, wr, cnt;
   logic [DATA_W-1:0] wdata;

   logic              accept;
   logic [ADDR_W-1:0] cmd_addr;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wval;
   logic [DATA_W-1:0] r1_next, r2_next;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == CLR);
   assign accept    = cmd_valid && cmd_ready;
   assign cmd_addr  = cmd_data[ADDR_W-1:0];

   // Single write port shared by WRITE commands and the CLEAR sweep; they never overlap.
   always_comb begin
      we    = 1'b0;
      waddr = wr;
      wval  = wdata;
      if (state == CLR) begin
         we    = 1'b1;
         waddr = cnt;
         wval  = '0;
      end else if (accept && cmd_op == OP_WRITE && !(ZERO_REG0 && wr == '0)) begin
         we = 1'b1;
      end
   end

   always_comb begin
      r1_next = mem[rr1];
      r2_next = mem[rr2];
      if (we && waddr == rr1) r1_next = wval;
      if (we && waddr == rr2) r2_next = wval;
      if (ZERO_REG0 && rr1 == '0) r1_next = '0;
      if (ZERO_REG0 && rr2 == '0) r2_next = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rr1      <= '0;
         rr2      <= '0;
         wr       <= '0;
         wdata    <= '0;
         out_r1   <= '0;
         out_r2   <= '0;
         wr_done  <= 1'b0;
         clr_done <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         out_r1   <= r1_next;
         out_r2   <= r2_next;
         wr_done  <= accept && (cmd_op == OP_WRITE);
         clr_done <= 1'b0;
         if (we) mem[waddr] <= wval;

         case (state)
            IDLE: begin
               if (accept) begin
                  case (cmd_op)
                     OP_SET_RR1:   rr1   <= cmd_addr;
                     OP_SET_RR2:   rr2   <= cmd_addr;
                     OP_SET_WR:    wr    <= cmd_addr;
                     OP_SET_WDATA: wdata <= cmd_data;
                     OP_CLEAR: begin
                        state <= CLR;
                        cnt   <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            CLR: begin
               if (cnt == LAST_IDX) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  clr_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_param : two parameterisations driven from one command stream,
//                    scoreboarded against a cycle-level behavioural model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_regfile_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'd0;

   logic       a_ready, a_busy, a_wrd, a_clrd;
   logic [3:0] a_r1, a_r2;
   logic       b_ready, b_busy, b_wrd, b_clrd;
   logic [7:0] b_r1, b_r2;

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(4), .ADDR_W(4), .ZERO_REG0(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data[3:0]), .out_r1(a_r1), .out_r2(a_r2),
      .busy(a_busy), .wr_done(a_wrd), .clr_done(a_clrd)
   );

   regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG0(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .out_r1(b_r1), .out_r2(b_r2),
      .busy(b_busy), .wr_done(b_wrd), .clr_done(b_clrd)
   );

   typedef struct packed {
      logic [7:0] r1;
      logic [7:0] r2;
      logic       busy;
      logic       ready;
      logic       wrd;
      logic       clrd;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   // Reference model state, one slot per instance.
   int aw[2] = '{4, 3};
   int dw[2] = '{4, 8};
   int zr[2] = '{0, 1};
   int m_mem[2][16];
   int m_rr1[2], m_rr2[2], m_wr[2], m_wdata[2];
   int m_clr_left[2], m_clr_idx[2];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic model_step(input int k, output exp_t e);
      int  depth, amask, dmask, d, wa, wd, o1, o2;
      bit  we, wrd, clrd;
      depth = 1 << aw[k];
      amask = depth - 1;
      dmask = (1 << dw[k]) - 1;
      we = 0; wrd = 0; clrd = 0; wa = 0; wd = 0; o1 = 0; o2 = 0;
      d = int'(cmd_data) & dmask;
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_mem[k][i] = 0;
         m_rr1[k] = 0; m_rr2[k] = 0; m_wr[k] = 0; m_wdata[k] = 0;
         m_clr_left[k] = 0; m_clr_idx[k] = 0;
      end else begin
         if (m_clr_left[k] > 0) begin
            we = 1; wa = m_clr_idx[k]; wd = 0;
         end else if (cmd_valid && cmd_op == 3'd5) begin
            wrd = 1;
            if (!(zr[k] != 0 && m_wr[k] == 0)) begin
               we = 1; wa = m_wr[k]; wd = m_wdata[k];
            end
         end
         o1 = (zr[k] != 0 && m_rr1[k] == 0) ? 0 : (we && wa == m_rr1[k]) ? wd : m_mem[k][m_rr1[k]];
         o2 = (zr[k] != 0 && m_rr2[k] == 0) ? 0 : (we && wa == m_rr2[k]) ? wd : m_mem[k][m_rr2[k]];
         if (we) m_mem[k][wa] = wd;
         if (m_clr_left[k] > 0) begin
            m_clr_idx[k]++;
            m_clr_left[k]--;
            clrd = (m_clr_left[k] == 0);
         end else if (cmd_valid) begin
            case (cmd_op)
               3'd1: m_rr1[k]   = d & amask;
               3'd2: m_rr2[k]   = d & amask;
               3'd3: m_wr[k]    = d & amask;
               3'd4: m_wdata[k] = d;
               3'd6: begin m_clr_left[k] = depth; m_clr_idx[k] = 0; end
               default: ;
            endcase
         end
      end
      e.r1    = 8'(o1);
      e.r2    = 8'(o2);
      e.busy  = (m_clr_left[k] > 0);
      e.ready = !(m_clr_left[k] > 0);
      e.wrd   = wrd;
      e.clrd  = clrd;
   endtask

   exp_t ea, eb;
   always @(posedge clk) begin
      model_step(0, ea);
      q_a.push_back(ea);
      model_step(1, eb);
      q_b.push_back(eb);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   exp_t ma, mb;
   always @(negedge clk) begin
      if (q_a.size() > 0) begin
         ma = q_a.pop_front();
         check("a_out_r1",    {4'd0, a_r1}, ma.r1);
         check("a_out_r2",    {4'd0, a_r2}, ma.r2);
         check("a_busy",      {7'd0, a_busy}, {7'd0, ma.busy});
         check("a_cmd_ready", {7'd0, a_ready}, {7'd0, ma.ready});
         check("a_wr_done",   {7'd0, a_wrd}, {7'd0, ma.wrd});
         check("a_clr_done",  {7'd0, a_clrd}, {7'd0, ma.clrd});
      end
      if (q_b.size() > 0) begin
         mb = q_b.pop_front();
         check("b_out_r1",    b_r1, mb.r1);
         check("b_out_r2",    b_r2, mb.r2);
         check("b_busy",      {7'd0, b_busy}, {7'd0, mb.busy});
         check("b_cmd_ready", {7'd0, b_ready}, {7'd0, mb.ready});
         check("b_wr_done",   {7'd0, b_wrd}, {7'd0, mb.wrd});
         check("b_clr_done",  {7'd0, b_clrd}, {7'd0, mb.clrd});
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] d);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         cmd_op    = 3'd0;
      end
   endtask

   // Hold the current command until both instances are ready to take it.
   task automatic hold_until_ready();
      int cyc;
      cyc = 0;
      while (!(a_ready && b_ready) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (!(a_ready && b_ready)) begin
         n_checks++;
         $display("FAIL ready_timeout: got ready=%b/%b expected 1/1", a_ready, b_ready);
      end
   endtask

   initial begin
      logic [2:0] op;
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Basic write then read through port 1.
      issue(3'd3, 8'h03); issue(3'd4, 8'h0A); issue(3'd5, 8'h00); issue(3'd1, 8'h03);
      idle(3);

      // Write-first bypass with both ports on the same register.
      issue(3'd1, 8'h05); issue(3'd2, 8'h05); issue(3'd3, 8'h05);
      issue(3'd4, 8'h02); issue(3'd5, 8'h00); issue(3'd4, 8'h07); issue(3'd5, 8'h00);
      idle(2);

      // Fill, CLEAR, command held through busy, then sweep reads.
      for (int i = 0; i < 16; i++) begin
         issue(3'd3, 8'(i)); issue(3'd4, 8'(i ^ 'hF)); issue(3'd5, 8'h00);
      end
      issue(3'd6, 8'h00);
      issue(3'd1, 8'h09);
      hold_until_ready();
      for (int i = 0; i < 16; i++) begin
         issue(3'd1, 8'(i)); issue(3'd2, 8'(15 - i));
      end
      idle(2);

      // Writes to register 0 (discarded only where it is hard-wired).
      issue(3'd3, 8'h00); issue(3'd4, 8'h0F); issue(3'd5, 8'h00); issue(3'd1, 8'h00);
      idle(2);

      // Upper address bits ignored.
      issue(3'd3, 8'hFB); issue(3'd4, 8'hC3); issue(3'd5, 8'h00);
      issue(3'd1, 8'h03); issue(3'd2, 8'h07);
      idle(3);

      // Reset in the middle of a CLEAR.
      issue(3'd6, 8'h00);
      idle(5);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(3);

      // Randomised traffic with rare CLEARs and occasional resets.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         op = 3'($urandom_range(0, 7));
         if (op == 3'd6 && $urandom_range(0, 5) != 0) op = 3'd5;
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_op    = op;
         cmd_data  = 8'($urandom);
         rst_n     = ($urandom_range(0, 199) != 0);
      end
      rst_n = 1'b1;
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
